instr_fetch: RTL and testbench

- Instruction fetch initiator that sits in front of the combinational word-addressed instruction memory.
- Drives the fetch PC, captures the returned instruction word, and buffers it with its PC in a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/call/return redirects from execute, and stops fetching after a HALT instruction.

---
 rtl/instr_fetch_pkg.sv | 34 +++
 rtl/instr_fetch_queue.sv | 77 +++++++
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch unit:
//     - instruction word width and opcode field position (top 5 bits)
//     - HALT opcode value
//     - fetch state encodings FS_RUN / FS_HALTED / FS_FAULT
//     - prefetch queue entry layout {pc, inst}
//   No ports (package).
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int WIDTH  = 32;             // instruction word width
    localparam int PC_W   = 32;             // word-address width
    localparam int OP_W   = 5;              // opcode field width
    localparam int OP_MSB = WIDTH - 1;      // opcode occupies the top OP_W bits

    localparam logic [OP_W-1:0] HALT = 5'h1F;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_HALTED = 2'd1,
        FS_FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [WIDTH-1:0] inst;
    } fetch_entry_t;

    function automatic logic is_halt(input logic [WIDTH-1:0] inst);
        return inst[OP_MSB -: OP_W] == HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Synchronous FIFO of {pc, inst} entries used as the prefetch queue.
//   A pop and a push in the same cycle are both honoured, including when the
//   queue is full. Flush empties the queue and drops any same-cycle push.
//   The head is read from registered storage and reads as zero while empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         empty the queue (overrides push/pop)
//   push_i          enqueue push_entry_i (ignored when full without a pop)
//   push_entry_i    entry to enqueue
//   pop_i           dequeue the head (ignored when empty)
//   head_valid_o    queue is non-empty
//   head_entry_o    head entry, zero when empty
//   count_o         number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  fetch_entry_t                   push_entry_i,
    input  logic                           pop_i,
    output logic                           head_valid_o,
    output fetch_entry_t                   head_entry_o,
    output logic [$clog2(DEPTH):0]         count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    fetch_entry_t     mem_q [DEPTH];

    logic pop_ok;
    logic push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && ((count_q != FULL_CNT) || pop_ok);

    // DEPTH is a power of two, so the pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: the storage array has no reset; count_q alone says which slots
    // hold data, so resetting the array would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_entry_o = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch initiator in front of a combinational, word-addressed
//   instruction memory. Drives the fetch PC, enqueues {pc, inst} into a
//   prefetch queue and presents the queue head to decode over valid/ready.
//   Execute may redirect fetch (flush + restart). Fetch stops after a HALT
//   word has been enqueued; the HALT word itself is still delivered.
//
// Configuration:
//   FETCH_BOUNDS_CHECK_EN  when defined, a fetch at pc >= IMEM_DEPTH is not
//                          pushed and the unit enters FS_FAULT (fetch_fault=1)
//                          until redirect or reset. When undefined there is
//                          no check and fetch_fault is constant 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_pc         word address to instruction memory (= fetch pc)
//   imem_inst       instruction word for imem_pc, same cycle
//   redirect_valid  one-cycle flush-and-restart pulse
//   redirect_pc     restart word address
//   inst_valid      queue head holds an instruction
//   inst_ready      decode accepts the head this cycle
//   inst_out        head instruction word (0 when empty)
//   inst_pc         head word address (0 when empty)
//   halted          HALT enqueued, fetching stopped
//   fetch_fault     bounds fault (0 when the check is compiled out)
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_pc,
    input  logic [WIDTH-1:0] imem_inst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_out,
    output logic [31:0]      inst_pc,
    output logic             halted,
    output logic             fetch_fault
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(QUEUE_DEPTH);

    if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 8 ||
        (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || IMEM_DEPTH < 1) begin : g_bad_params
        $error("instr_fetch: QUEUE_DEPTH must be a power of two in 2..8 and IMEM_DEPTH >= 1");
    end

    fetch_state_e     state_q;
    logic [31:0]      fetch_pc_q;
    logic             halted_q;

    logic             q_head_valid;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     push_entry;

    logic             pop;
    logic             fetch_slot;
    logic             push;

    assign pop        = q_head_valid && inst_ready;
    // A slot opens when the queue has room, or when the head leaves this cycle.
    assign fetch_slot = (state_q == FS_RUN) && ((q_count < Q_FULL) || pop);
    assign push_entry = '{pc: fetch_pc_q, inst: imem_inst};

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH);

    logic in_range;
    logic fault_q;

    assign in_range = (fetch_pc_q < IMEM_LIMIT);
    assign push     = fetch_slot && in_range;
`else
    assign push     = fetch_slot;
`endif

    // Fetch FSM. Reset beats redirect; redirect beats normal fetch, so a push
    // in the redirect cycle never advances the pc or raises halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_RUN;
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            state_q    <= FS_RUN;
            fetch_pc_q <= redirect_pc;
            halted_q   <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                FS_RUN: begin
                    if (push) begin
                        // The HALT word is enqueued but the pc stays on it.
                        if (is_halt(imem_inst)) begin
                            state_q  <= FS_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            fetch_pc_q <= fetch_pc_q + 32'd1;
                        end
                    end
`ifdef FETCH_BOUNDS_CHECK_EN
                    else if (!in_range) begin
                        state_q <= FS_FAULT;
                        fault_q <= 1'b1;
                    end
`endif
                end
                FS_HALTED, FS_FAULT: begin
                    // Parked until redirect or reset; the queue keeps draining.
                end
                default: state_q <= FS_RUN;
            endcase
        end
    end

    instr_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_valid_o (q_head_valid),
        .head_entry_o (q_head),
        .count_o      (q_count)
    );

    assign imem_pc    = fetch_pc_q;
    assign inst_valid = q_head_valid;
    assign inst_out   = q_head.inst;
    assign inst_pc    = q_head.pc;
    assign halted     = halted_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch (RESET_PC=0, QUEUE_DEPTH=2,
//   IMEM_DEPTH=16). Memory: HALT at word 7, every other word is a non-HALT
//   opcode carrying its own address. A table of per-cycle vectors covers
//   reset, streaming to HALT, redirect out of HALT, mid-stream reset, ready
//   back-pressure and redirect over a full queue; a hand-written sequence
//   covers the fetch bounds behaviour (FETCH_BOUNDS_CHECK_EN on or off).
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        halted;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd7) return {5'h1F, 27'd7};
        return {5'h01, a[26:0]};
    endfunction

    assign imem_inst = mem_word(imem_pc);

    instr_fetch #(
        .RESET_PC    (32'd0),
        .QUEUE_DEPTH (2),
        .IMEM_DEPTH  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_halted;
        logic [31:0] e_imem_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 ns after the edge.
    task automatic step(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
        rst            = r;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic ev, input logic [31:0] epc,
                              input logic eh, input logic [31:0] eimem, input logic ef);
        check({tag, " inst_valid"},  {31'd0, inst_valid},  {31'd0, ev});
        check({tag, " inst_pc"},     inst_pc,              ev ? epc : 32'd0);
        check({tag, " inst_out"},    inst_out,             ev ? mem_word(epc) : 32'd0);
        check({tag, " halted"},      {31'd0, halted},      {31'd0, eh});
        check({tag, " imem_pc"},     imem_pc,              eimem);
        check({tag, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, ef});
    endtask

    function automatic vec_t v(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc, input logic eh,
                               input logic [31:0] eimem);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.redir = redir; t.rpc = rpc;
        t.e_valid = ev; t.e_pc = epc; t.e_halted = eh; t.e_imem_pc = eimem;
        return t;
    endfunction

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        //                 rst rdy rdr rpc   valid pc  halt imem
        // reset, then stream 0..7 ending in HALT
        vecs.push_back(v(1, 1, 0, 0,    0, 0,  0, 0));
        vecs.push_back(v(0, 1, 0, 0,    1, 0,  0, 1));
        vecs.push_back(v(0, 1, 0, 0,    1, 1,  0, 2));
        vecs.push_back(v(0, 1, 0, 0,    1, 2,  0, 3));
        vecs.push_back(v(0, 1, 0, 0,    1, 3,  0, 4));
        vecs.push_back(v(0, 1, 0, 0,    1, 4,  0, 5));
        vecs.push_back(v(0, 1, 0, 0,    1, 5,  0, 6));
        vecs.push_back(v(0, 1, 0, 0,    1, 6,  0, 7));
        vecs.push_back(v(0, 1, 0, 0,    1, 7,  1, 7));
        vecs.push_back(v(0, 1, 0, 0,    0, 0,  1, 7));
        vecs.push_back(v(0, 1, 0, 0,    0, 0,  1, 7));
        // redirect to 8 while halted
        vecs.push_back(v(0, 1, 1, 8,    0, 0,  0, 8));
        vecs.push_back(v(0, 1, 0, 0,    1, 8,  0, 9));
        vecs.push_back(v(0, 1, 0, 0,    1, 9,  0, 10));
        vecs.push_back(v(0, 1, 0, 0,    1, 10, 0, 11));
        // fill the queue, then reset mid-stream
        vecs.push_back(v(0, 0, 0, 0,    1, 10, 0, 12));
        vecs.push_back(v(0, 0, 0, 0,    1, 10, 0, 12));
        vecs.push_back(v(1, 0, 0, 0,    0, 0,  0, 0));
        // ready low for 5 cycles: queue saturates at pc 0,1
        vecs.push_back(v(0, 0, 0, 0,    1, 0,  0, 1));
        vecs.push_back(v(0, 0, 0, 0,    1, 0,  0, 2));
        vecs.push_back(v(0, 0, 0, 0,    1, 0,  0, 2));
        vecs.push_back(v(0, 0, 0, 0,    1, 0,  0, 2));
        vecs.push_back(v(0, 0, 0, 0,    1, 0,  0, 2));
        // release: pop+push on a full queue keeps streaming
        vecs.push_back(v(0, 1, 0, 0,    1, 1,  0, 3));
        vecs.push_back(v(0, 1, 0, 0,    1, 2,  0, 4));
        vecs.push_back(v(0, 1, 0, 0,    1, 3,  0, 5));
        vecs.push_back(v(0, 1, 0, 0,    1, 4,  0, 6));
        vecs.push_back(v(0, 1, 0, 0,    1, 5,  0, 7));
        // queue holds 5,6 and imem shows HALT: redirect to 2 wins
        vecs.push_back(v(0, 1, 1, 2,    0, 0,  0, 2));
        vecs.push_back(v(0, 1, 0, 0,    1, 2,  0, 3));
        vecs.push_back(v(0, 1, 0, 0,    1, 3,  0, 4));
        vecs.push_back(v(0, 1, 0, 0,    1, 4,  0, 5));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            check_head($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                       vecs[i].e_halted, vecs[i].e_imem_pc, 1'b0);
        end

        // Bounds sequence: redirect to 14, stream across IMEM_DEPTH=16.
        step(0, 1, 1, 32'd14);
        check_head("bnd redirect", 1'b0, 32'd0,  1'b0, 32'd14, 1'b0);
        step(0, 1, 0, 32'd0);
        check_head("bnd pc14",     1'b1, 32'd14, 1'b0, 32'd15, 1'b0);
        step(0, 1, 0, 32'd0);
        check_head("bnd pc15",     1'b1, 32'd15, 1'b0, 32'd16, 1'b0);
`ifdef FETCH_BOUNDS_CHECK_EN
        step(0, 1, 0, 32'd0);
        check_head("bnd fault",    1'b0, 32'd0,  1'b0, 32'd16, 1'b1);
        step(0, 1, 0, 32'd0);
        check_head("bnd hold",     1'b0, 32'd0,  1'b0, 32'd16, 1'b1);
`else
        step(0, 1, 0, 32'd0);
        check_head("bnd pc16",     1'b1, 32'd16, 1'b0, 32'd17, 1'b0);
        step(0, 1, 0, 32'd0);
        check_head("bnd pc17",     1'b1, 32'd17, 1'b0, 32'd18, 1'b0);
`endif
        step(0, 1, 1, 32'd0);
        check_head("bnd clear",    1'b0, 32'd0,  1'b0, 32'd0,  1'b0);
        step(0, 1, 0, 32'd0);
        check_head("bnd pc0",      1'b1, 32'd0,  1'b0, 32'd1,  1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
